// File: rtl/flip_sequencer_if.sv
// Selection and reveal-timer signals between the card-flip sequencer and
// its neighbours. master = selection front-end / timer side, slave = sequencer.
interface flip_sequencer_if #(
    parameter int IDX_W   = 4,
    parameter int SYM_W   = 3,
    parameter int DELAY_W = 16
);
    // Handshakes:
    //  - A selection transfers on a rising clk edge where sel_valid && sel_ready.
    //    It is taken only if sel_idx is on the board and that card is face-down;
    //    otherwise it is dropped silently. sel_valid needs no ready-wait.
    //  - timer_start is a level held while the pair is shown. timer_delay is
    //    constant. timer_done is a 1-cycle pulse that ends the wait; it is
    //    ignored whenever timer_start is low.
    logic               sel_valid;
    logic [IDX_W-1:0]   sel_idx;
    logic [SYM_W-1:0]   sel_sym;
    logic               sel_ready;
    logic               timer_start;
    logic [DELAY_W-1:0] timer_delay;
    logic               timer_done;

    modport master (
        output sel_valid, sel_idx, sel_sym, timer_done,
        input  sel_ready, timer_start, timer_delay
    );

    modport slave (
        input  sel_valid, sel_idx, sel_sym, timer_done,
        output sel_ready, timer_start, timer_delay
    );
endinterface

// File: rtl/flip_sequencer.sv
// Game-flow controller for the card-flip memory game: two picks, timed reveal,
// then commit match or flip back. Define MOVE_LIMIT_EN to end the game at MAX_MOVES.
module flip_sequencer #(
    parameter int NUM_CARDS    = 16,
    parameter int IDX_W        = 4,
    parameter int SYM_W        = 3,
    parameter int DELAY_W      = 16,
    parameter int REVEAL_DELAY = 50000,
    parameter int MAX_MOVES    = 20
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 start,
    flip_sequencer_if.slave      bus,
    output logic [NUM_CARDS-1:0] revealed_mask,
    output logic [NUM_CARDS-1:0] matched_mask,
    output logic                 match_pulse,
    output logic                 mismatch_pulse,
    output logic [7:0]           moves,
    output logic                 game_over,
    output logic                 game_lost,
    output logic [2:0]           state_dbg
);

`ifdef MOVE_LIMIT_EN
    localparam bit LIMIT_EN = 1'b1;
`else
    localparam bit LIMIT_EN = 1'b0;
`endif

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        PICK1   = 3'd1,
        PICK2   = 3'd2,
        HOLD    = 3'd3,
        RESOLVE = 3'd4,
        DONE    = 3'd5
    } state_t;

    state_t             state;
    logic [IDX_W-1:0]   idx1, idx2;
    logic [SYM_W-1:0]   sym1, sym2;
    logic [NUM_CARDS-1:0] sel_bit, pair_bits, matched_next;
    logic               sel_ok, sym_eq, board_full, limit_hit;
    logic [7:0]         moves_inc;

    // An out-of-range index shifts to zero, so the range check is what rejects it.
    assign sel_bit      = NUM_CARDS'(1) << bus.sel_idx;
    assign sel_ok       = bus.sel_valid
                        && ({1'b0, bus.sel_idx} < (IDX_W+1)'(NUM_CARDS))
                        && ((revealed_mask & sel_bit) == '0);
    assign pair_bits    = (NUM_CARDS'(1) << idx1) | (NUM_CARDS'(1) << idx2);
    assign sym_eq       = (sym1 == sym2);
    assign matched_next = sym_eq ? (matched_mask | pair_bits) : matched_mask;
    assign board_full   = &matched_next;
    assign moves_inc    = (moves == 8'hFF) ? moves : moves + 8'd1;
    assign limit_hit    = LIMIT_EN && (moves_inc == 8'(MAX_MOVES));

    assign bus.timer_delay = DELAY_W'(REVEAL_DELAY);
    assign state_dbg       = state;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state           <= IDLE;
            idx1            <= '0;
            idx2            <= '0;
            sym1            <= '0;
            sym2            <= '0;
            revealed_mask   <= '0;
            matched_mask    <= '0;
            match_pulse     <= 1'b0;
            mismatch_pulse  <= 1'b0;
            moves           <= '0;
            game_over       <= 1'b0;
            game_lost       <= 1'b0;
            bus.sel_ready   <= 1'b0;
            bus.timer_start <= 1'b0;
        end else begin
            match_pulse    <= 1'b0;
            mismatch_pulse <= 1'b0;
            if (start) begin
                state           <= PICK1;
                revealed_mask   <= '0;
                matched_mask    <= '0;
                moves           <= '0;
                game_over       <= 1'b0;
                game_lost       <= 1'b0;
                bus.sel_ready   <= 1'b1;
                bus.timer_start <= 1'b0;
            end else begin
                case (state)
                    PICK1: if (sel_ok) begin
                        idx1          <= bus.sel_idx;
                        sym1          <= bus.sel_sym;
                        revealed_mask <= revealed_mask | sel_bit;
                        state         <= PICK2;
                    end
                    PICK2: if (sel_ok) begin
                        idx2            <= bus.sel_idx;
                        sym2            <= bus.sel_sym;
                        revealed_mask   <= revealed_mask | sel_bit;
                        state           <= HOLD;
                        bus.sel_ready   <= 1'b0;
                        bus.timer_start <= 1'b1;
                    end
                    HOLD: if (bus.timer_done) begin
                        state           <= RESOLVE;
                        bus.timer_start <= 1'b0;
                    end
                    RESOLVE: begin
                        moves        <= moves_inc;
                        matched_mask <= matched_next;
                        if (sym_eq) begin
                            match_pulse <= 1'b1;
                        end else begin
                            revealed_mask  <= revealed_mask & ~pair_bits;
                            mismatch_pulse <= 1'b1;
                        end
                        // A completed board wins over the move limit.
                        if (board_full || limit_hit) begin
                            state     <= DONE;
                            game_over <= 1'b1;
                            game_lost <= !board_full;
                        end else begin
                            state         <= PICK1;
                            bus.sel_ready <= 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_flip_sequencer.sv
// Bench for flip_sequencer: directed scenarios with literal checks, then random
// play, all tracked by a pick-queue model compared every cycle.
module tb_flip_sequencer;
    localparam int NUM_CARDS    = 16;
    localparam int IDX_W        = 5;
    localparam int SYM_W        = 3;
    localparam int DELAY_W      = 16;
    localparam int REVEAL_DELAY = 4;
    localparam int MAX_MOVES    = 3;
`ifdef MOVE_LIMIT_EN
    localparam bit LIM = 1'b1;
`else
    localparam bit LIM = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset_n;
    logic        start;
    logic [15:0] revealed_mask, matched_mask;
    logic        match_pulse, mismatch_pulse;
    logic [7:0]  moves;
    logic        game_over, game_lost;
    logic [2:0]  state_dbg;

    flip_sequencer_if #(.IDX_W(IDX_W), .SYM_W(SYM_W), .DELAY_W(DELAY_W)) bus ();

    flip_sequencer #(
        .NUM_CARDS(NUM_CARDS), .IDX_W(IDX_W), .SYM_W(SYM_W), .DELAY_W(DELAY_W),
        .REVEAL_DELAY(REVEAL_DELAY), .MAX_MOVES(MAX_MOVES)
    ) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .bus(bus),
        .revealed_mask(revealed_mask), .matched_mask(matched_mask),
        .match_pulse(match_pulse), .mismatch_pulse(mismatch_pulse),
        .moves(moves), .game_over(game_over), .game_lost(game_lost),
        .state_dbg(state_dbg)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- scoreboard counters ----------------
    int n_cmp = 0;
    int n_bad = 0;

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // The game is a queue of face-up unresolved picks; two picks wait for the
    // timer, then one more cycle settles them.
    logic [15:0] m_rev = '0, m_mat = '0;
    int          m_moves = 0;
    bit          m_lost = 0, m_active = 0, m_over = 0, m_due = 0, m_mp = 0, m_mmp = 0;
    int          q_idx[$];
    int          q_sym[$];

    always @(posedge clk or negedge reset_n) begin
        int a, b, ix;
        if (!reset_n) begin
            m_rev = '0; m_mat = '0; m_moves = 0; m_lost = 0;
            m_active = 0; m_over = 0; m_due = 0; m_mp = 0; m_mmp = 0;
            q_idx.delete(); q_sym.delete();
        end else begin
            m_mp = 0; m_mmp = 0;
            ix = int'(bus.sel_idx);
            if (start) begin
                m_rev = '0; m_mat = '0; m_moves = 0; m_lost = 0;
                m_active = 1; m_over = 0; m_due = 0;
                q_idx.delete(); q_sym.delete();
            end else if (m_active && !m_over) begin
                if (m_due) begin
                    m_due = 0;
                    a = q_idx[0]; b = q_idx[1];
                    m_moves = (m_moves < 255) ? m_moves + 1 : 255;
                    if (q_sym[0] == q_sym[1]) begin
                        m_mat[a] = 1'b1; m_mat[b] = 1'b1; m_mp = 1;
                    end else begin
                        m_rev[a] = 1'b0; m_rev[b] = 1'b0; m_mmp = 1;
                    end
                    q_idx.delete(); q_sym.delete();
                    if (m_mat == 16'hFFFF) m_over = 1;
                    else if (LIM && m_moves == MAX_MOVES) begin
                        m_over = 1; m_lost = 1;
                    end
                end else if (q_idx.size() == 2) begin
                    if (bus.timer_done) m_due = 1;
                end else if (bus.sel_valid && ix < NUM_CARDS) begin
                    if (!m_rev[ix]) begin
                        q_idx.push_back(ix);
                        q_sym.push_back(int'(bus.sel_sym));
                        m_rev[ix] = 1'b1;
                    end
                end
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        bit run;
        run = m_active && !m_over;
        cmp("sel_ready",   bus.sel_ready,   32'(run && q_idx.size() < 2));
        cmp("timer_start", bus.timer_start, 32'(run && q_idx.size() == 2 && !m_due));
        cmp("timer_delay", bus.timer_delay, 32'(REVEAL_DELAY));
        cmp("revealed",    revealed_mask,   32'(m_rev));
        cmp("matched",     matched_mask,    32'(m_mat));
        cmp("match_pulse", match_pulse,     32'(m_mp));
        cmp("mismatch_pulse", mismatch_pulse, 32'(m_mmp));
        cmp("moves",       moves,           32'(m_moves));
        cmp("game_over",   game_over,       32'(m_active && m_over));
        cmp("game_lost",   game_lost,       32'(m_lost));
    end

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic pick(input int idx, input int sym);
        bus.sel_valid = 1'b1;
        bus.sel_idx   = IDX_W'(idx);
        bus.sel_sym   = SYM_W'(sym);
        step();
        bus.sel_valid = 1'b0;
    endtask

    task automatic pulse_done();
        bus.timer_done = 1'b1;
        step();
        bus.timer_done = 1'b0;
    endtask

    task automatic do_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        reset_n = 1'b0; start = 1'b0;
        bus.sel_valid = 1'b0; bus.sel_idx = '0; bus.sel_sym = '0; bus.timer_done = 1'b0;
        repeat (2) step();
        reset_n = 1'b1;
        step();
        cmp("rst_revealed", revealed_mask, 0);
        cmp("rst_ready", bus.sel_ready, 0);
        cmp("rst_state", state_dbg, 0);
        cmp("rst_moves", moves, 0);

        // Match: cards 2 and 9 share symbol 5.
        do_start();
        pick(2, 5); pick(9, 5);
        repeat (2) step();
        cmp("hold_tstart", bus.timer_start, 1);
        pulse_done();
        step();
        cmp("match_pulse_lit", match_pulse, 1);
        cmp("match_matched", matched_mask, 16'h0204);
        cmp("match_revealed", revealed_mask, 16'h0204);
        cmp("match_moves", moves, 1);
        step();
        cmp("match_pulse_len", match_pulse, 0);

        // Mismatch: cards 0 and 1 differ.
        pick(0, 1); pick(1, 3);
        cmp("mm_shown", revealed_mask, 16'h0207);
        cmp("mm_tstart", bus.timer_start, 1);
        pulse_done();
        cmp("resolve_tstart", bus.timer_start, 0);
        step();
        cmp("mm_pulse_lit", mismatch_pulse, 1);
        cmp("mm_revealed", revealed_mask, 16'h0204);
        cmp("mm_moves", moves, 2);

        // Rejected selections and a stray timer_done.
        pick(2, 5);
        cmp("rej_matched", revealed_mask, 16'h0204);
        pick(16, 0);
        cmp("rej_range", revealed_mask, 16'h0204);
        pulse_done();
        cmp("rej_done_tstart", bus.timer_start, 0);
        cmp("rej_done_moves", moves, 2);
        pick(4, 2); pick(4, 2);
        cmp("rej_same", revealed_mask, 16'h0214);
        cmp("rej_same_ready", bus.sel_ready, 1);
        pick(5, 2);
        pick(6, 2);
        cmp("rej_hold", revealed_mask, 16'h0234);
        cmp("rej_hold_ready", bus.sel_ready, 0);
        pulse_done(); step();
        cmp("rej_matched2", matched_mask, 16'h0234);
        cmp("rej_moves3", moves, 3);
        cmp("rej_over", game_over, 32'(LIM));

        // Asynchronous reset in the middle of HOLD.
        do_start();
        pick(0, 0); pick(1, 1);
        cmp("prerst_tstart", bus.timer_start, 1);
        #1 reset_n = 1'b0;
        #1;
        cmp("async_tstart", bus.timer_start, 0);
        cmp("async_revealed", revealed_mask, 0);
        cmp("async_state", state_dbg, 0);
        cmp("async_delay", bus.timer_delay, REVEAL_DELAY);
        step();
        reset_n = 1'b1;
        step();

        // Full game: card i pairs with card i+8.
        do_start();
        for (int p = 0; p < 8; p++) begin
            pick(p, p); pick(p + 8, p);
            pulse_done(); step();
        end
        cmp("full_over", game_over, 1);
        cmp("full_matched", matched_mask, LIM ? 16'h0707 : 16'hFFFF);
        cmp("full_moves", moves, LIM ? 3 : 8);
        cmp("full_lost", game_lost, 32'(LIM));

        do_start();
        cmp("restart_matched", matched_mask, 0);
        cmp("restart_moves", moves, 0);
        cmp("restart_ready", bus.sel_ready, 1);

        // start aborts PICK2 and overrides a same-cycle selection.
        pick(3, 1);
        cmp("abort_pre", revealed_mask, 16'h0008);
        start = 1'b1; bus.sel_valid = 1'b1; bus.sel_idx = 5'd5;
        step();
        start = 1'b0; bus.sel_valid = 1'b0;
        cmp("abort_revealed", revealed_mask, 0);
        pick(5, 1);
        cmp("abort_pick", revealed_mask, 16'h0020);

        // Four mismatches in a row.
        do_start();
        for (int k = 0; k < 4; k++) begin
            pick(2 * k, 0); pick(2 * k + 1, 1);
            pulse_done(); step();
        end
        cmp("limit_moves", moves, LIM ? 3 : 4);
        cmp("limit_lost", game_lost, 32'(LIM));
        cmp("limit_over", game_over, 32'(LIM));

        // Random play against the model.
        do_start();
        for (int c = 0; c < 3000; c++) begin
            start         = ($urandom_range(0, 199) == 0);
            bus.sel_valid = 1'($urandom_range(0, 1));
            bus.sel_idx   = IDX_W'($urandom_range(0, 17));
            bus.sel_sym   = ($urandom_range(0, 3) == 0) ? SYM_W'($urandom_range(0, 7))
                                                        : bus.sel_idx[2:0];
            bus.timer_done = ($urandom_range(0, 3) == 0);
            step();
        end
        start = 1'b0; bus.sel_valid = 1'b0; bus.timer_done = 1'b0;
        repeat (3) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
